// File: rtl/rsz_pxl_buf.sv
// Ping-pong row buffer between the resize compute engine and a valid/ready pixel consumer.
// Rows are captured by one-hot X/Y masks (Y parity picks the bank) and streamed out in column order.
module rsz_pxl_buf #(
   parameter int RSZ_W     = 8,
   parameter int RSZ_H     = 8,
   parameter int COLOR_NUM = 3,
   parameter int COLOR_W   = 8
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic [COLOR_NUM*COLOR_W-1:0] CeRszPxlData,
   input  logic [RSZ_W-1:0]             CeRszPxlXMsk,
   input  logic [RSZ_H-1:0]             CeRszPxlYMsk,
   input  logic                         CeCompVld,
   output logic [COLOR_NUM*COLOR_W-1:0] OutPxlData,
   output logic                         OutVld,
   input  logic                         OutRdy,
   output logic                         OutEol,
   output logic                         OutEoi,
   output logic                         RszImgComp,
   output logic                         BufOvf,
   output logic                         MskErr
);

   localparam int PXL_W = COLOR_NUM * COLOR_W;
   localparam int XW    = (RSZ_W > 1) ? $clog2(RSZ_W) : 1;
   localparam int YW    = $clog2(RSZ_H);
   localparam logic [XW-1:0] LAST_X = XW'(RSZ_W - 1);
   localparam logic [YW-1:0] LAST_Y = YW'(RSZ_H - 1);

   logic [PXL_W-1:0]          bank0_q [RSZ_W];
   logic [PXL_W-1:0]          bank1_q [RSZ_W];
   logic [1:0][RSZ_W-1:0]     wr_msk_q, wr_msk_d;
   logic [1:0]                full_q, full_d;
   logic                      rd_bank_q, rd_bank_d;
   logic [XW-1:0]             rd_x_q, rd_x_d;
   logic [YW-1:0]             rd_row_q, rd_row_d;
   logic                      img_comp_q, img_comp_d;
   logic                      ovf_q, ovf_d;
   logic                      msk_err_q, msk_err_d;

   logic                      x_onehot, y_onehot, wr_ok, wr_en, wr_bank, pop;
   logic [XW-1:0]             wr_x;
   logic [RSZ_W-1:0]          new_msk;
   logic [PXL_W-1:0]          rd_pxl;

   always_comb begin
      x_onehot = (CeRszPxlXMsk != '0) && ((CeRszPxlXMsk & (CeRszPxlXMsk - 1'b1)) == '0);
      y_onehot = (CeRszPxlYMsk != '0) && ((CeRszPxlYMsk & (CeRszPxlYMsk - 1'b1)) == '0);
      wr_x = '0;
      for (int i = 0; i < RSZ_W; i++) begin
         if (CeRszPxlXMsk[i]) wr_x = XW'(i);
      end
      // Odd rows land in bank 1.
      wr_bank = 1'b0;
      for (int i = 1; i < RSZ_H; i += 2) begin
         wr_bank = wr_bank | CeRszPxlYMsk[i];
      end
      wr_ok = CeCompVld && x_onehot && y_onehot;
      wr_en = wr_ok && !full_q[wr_bank];
   end

   always_comb begin
      OutVld     = full_q[rd_bank_q];
      rd_pxl     = rd_bank_q ? bank1_q[rd_x_q] : bank0_q[rd_x_q];
      OutPxlData = OutVld ? rd_pxl : '0;
      OutEol     = OutVld && (rd_x_q == LAST_X);
      OutEoi     = OutEol && (rd_row_q == LAST_Y);
      pop        = OutVld && OutRdy;
      RszImgComp = img_comp_q;
      BufOvf     = ovf_q;
      MskErr     = msk_err_q;
   end

   always_comb begin
      wr_msk_d   = wr_msk_q;
      full_d     = full_q;
      rd_bank_d  = rd_bank_q;
      rd_x_d     = rd_x_q;
      rd_row_d   = rd_row_q;
      new_msk    = '0;
      img_comp_d = pop && OutEoi;
      ovf_d      = ovf_q | (wr_ok && full_q[wr_bank]);
      msk_err_d  = msk_err_q | (CeCompVld && !(x_onehot && y_onehot));

      if (pop) begin
         if (OutEol) begin
            rd_x_d            = '0;
            full_d[rd_bank_q] = 1'b0;
            if (OutEoi) begin
               rd_row_d  = '0;
               rd_bank_d = 1'b0;
            end else begin
               rd_row_d  = rd_row_q + YW'(1);
               rd_bank_d = ~rd_bank_q;
            end
         end else begin
            rd_x_d = rd_x_q + XW'(1);
         end
      end

      // A write can never target the bank being popped: that bank is full, so the write drops.
      if (wr_en) begin
         new_msk = wr_msk_q[wr_bank] | CeRszPxlXMsk;
         if (&new_msk) begin
            full_d[wr_bank]   = 1'b1;
            wr_msk_d[wr_bank] = '0;
         end else begin
            wr_msk_d[wr_bank] = new_msk;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wr_msk_q   <= '0;
         full_q     <= '0;
         rd_bank_q  <= 1'b0;
         rd_x_q     <= '0;
         rd_row_q   <= '0;
         img_comp_q <= 1'b0;
         ovf_q      <= 1'b0;
         msk_err_q  <= 1'b0;
      end else begin
         wr_msk_q   <= wr_msk_d;
         full_q     <= full_d;
         rd_bank_q  <= rd_bank_d;
         rd_x_q     <= rd_x_d;
         rd_row_q   <= rd_row_d;
         img_comp_q <= img_comp_d;
         ovf_q      <= ovf_d;
         msk_err_q  <= msk_err_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (wr_en) begin
         if (wr_bank) bank1_q[wr_x] <= CeRszPxlData;
         else         bank0_q[wr_x] <= CeRszPxlData;
      end
   end

endmodule

// File: tb/tb_rsz_pxl_buf.sv
// Directed plus random bench for rsz_pxl_buf; outputs are compared each cycle against a
// queue-based model of completed rows awaiting streaming.
module tb_rsz_pxl_buf;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int PW = 24;

   logic          Clk = 1'b0;
   logic          Reset;
   logic [PW-1:0] CeRszPxlData;
   logic [W-1:0]  CeRszPxlXMsk;
   logic [H-1:0]  CeRszPxlYMsk;
   logic          CeCompVld;
   logic [PW-1:0] OutPxlData;
   logic          OutVld;
   logic          OutRdy;
   logic          OutEol;
   logic          OutEoi;
   logic          RszImgComp;
   logic          BufOvf;
   logic          MskErr;

   int n_err    = 0;
   int n_checks = 0;

   rsz_pxl_buf #(.RSZ_W(W), .RSZ_H(H), .COLOR_NUM(3), .COLOR_W(8)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .CeRszPxlData (CeRszPxlData),
      .CeRszPxlXMsk (CeRszPxlXMsk),
      .CeRszPxlYMsk (CeRszPxlYMsk),
      .CeCompVld    (CeCompVld),
      .OutPxlData   (OutPxlData),
      .OutVld       (OutVld),
      .OutRdy       (OutRdy),
      .OutEol       (OutEol),
      .OutEoi       (OutEoi),
      .RszImgComp   (RszImgComp),
      .BufOvf       (BufOvf),
      .MskErr       (MskErr)
   );

   always #5 Clk = ~Clk;

   // Reference model: each bank is either collecting a row or holds a finished row as a queue.
   logic [PW-1:0] exp_q0[$];
   logic [PW-1:0] exp_q1[$];
   logic [PW-1:0] pend_dat [2][W];
   bit            pend_seen [2][W];
   int            m_rd_bank, m_rd_row;
   bit            m_comp, m_ovf, m_err;

   function automatic int bsize(input int b);
      return (b == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   function automatic logic [PW-1:0] bfront(input int b);
      return (b == 0) ? exp_q0[0] : exp_q1[0];
   endfunction

   function automatic int onehot_idx(input logic [31:0] v, input int n);
      int idx = -1;
      int cnt = 0;
      for (int i = 0; i < n; i++) begin
         if (v[i]) begin
            cnt++;
            idx = i;
         end
      end
      return (cnt == 1) ? idx : -1;
   endfunction

   task automatic m_reset();
      exp_q0.delete();
      exp_q1.delete();
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < W; i++) pend_seen[b][i] = 0;
      m_rd_bank = 0;
      m_rd_row  = 0;
      m_comp    = 0;
      m_ovf     = 0;
      m_err     = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_outputs();
      bit hv, eol, eoi;
      hv  = bsize(m_rd_bank) > 0;
      eol = hv && (bsize(m_rd_bank) == 1);
      eoi = eol && (m_rd_row == H - 1);
      chk("out_vld", 32'(OutVld), 32'(hv));
      chk("out_eol", 32'(OutEol), 32'(eol));
      chk("out_eoi", 32'(OutEoi), 32'(eoi));
      chk("img_comp", 32'(RszImgComp), 32'(m_comp));
      chk("buf_ovf", 32'(BufOvf), 32'(m_ovf));
      chk("msk_err", 32'(MskErr), 32'(m_err));
      if (hv) chk("out_data", 32'(OutPxlData), 32'(bfront(m_rd_bank)));
   endtask

   task automatic model_edge(input bit vld, input logic [W-1:0] x, input logic [H-1:0] y,
                             input logic [PW-1:0] d, input bit rdy);
      bit hv, pop, eoi, do_wr, all_seen;
      int xi, yi, b;
      hv    = bsize(m_rd_bank) > 0;
      pop   = hv && rdy;
      eoi   = hv && (bsize(m_rd_bank) == 1) && (m_rd_row == H - 1);
      do_wr = 0;
      b     = 0;
      xi    = onehot_idx(32'(x), W);
      yi    = onehot_idx(32'(y), H);
      if (vld) begin
         if (xi < 0 || yi < 0) m_err = 1;
         else begin
            b = yi % 2;
            if (bsize(b) > 0) m_ovf = 1;
            else do_wr = 1;
         end
      end
      m_comp = pop && eoi;
      if (pop) begin
         if (m_rd_bank == 0) void'(exp_q0.pop_front());
         else                void'(exp_q1.pop_front());
         if (bsize(m_rd_bank) == 0) begin
            m_rd_row++;
            m_rd_bank ^= 1;
            if (m_rd_row == H) begin
               m_rd_row  = 0;
               m_rd_bank = 0;
            end
         end
      end
      if (do_wr) begin
         pend_dat[b][xi]  = d;
         pend_seen[b][xi] = 1;
         all_seen = 1;
         for (int i = 0; i < W; i++) all_seen &= pend_seen[b][i];
         if (all_seen) begin
            for (int i = 0; i < W; i++) begin
               if (b == 0) exp_q0.push_back(pend_dat[b][i]);
               else        exp_q1.push_back(pend_dat[b][i]);
               pend_seen[b][i] = 0;
            end
         end
      end
   endtask

   task automatic step(input bit vld, input logic [W-1:0] x, input logic [H-1:0] y,
                       input logic [PW-1:0] d, input bit rdy);
      CeCompVld    = vld;
      CeRszPxlXMsk = x;
      CeRszPxlYMsk = y;
      CeRszPxlData = d;
      OutRdy       = rdy;
      @(negedge Clk);
      check_outputs();
      if (Reset) model_edge(vld, x, y, d, rdy);
      @(posedge Clk);
      #1;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, '0, '0, '0, rdy);
   endtask

   task automatic write_row(input int row, input bit rdy, input logic [PW-1:0] base);
      for (int c = 0; c < W; c++)
         step(1, W'(1) << c, H'(1) << row, base * PW'(c + 1), rdy);
   endtask

   initial begin
      logic [W-1:0]  xr;
      logic [H-1:0]  yr;
      logic [PW-1:0] dr;
      int            order [4];
      Reset        = 1'b0;
      CeCompVld    = 1'b0;
      CeRszPxlXMsk = '0;
      CeRszPxlYMsk = '0;
      CeRszPxlData = '0;
      OutRdy       = 1'b0;
      m_reset();
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_vld", 32'(OutVld), 32'd0);
      chk("rst_comp", 32'(RszImgComp), 32'd0);
      Reset = 1'b1;

      // Row 0 in order, consumer always ready.
      write_row(0, 1, 24'h010101);
      idle(6, 1);

      // Row 1 out of order: columns 2,0,3,1.
      order = '{2, 0, 3, 1};
      for (int i = 0; i < 4; i++)
         step(1, W'(1) << order[i], 2'b10, 24'h111111 * PW'(order[i]), 1);
      idle(6, 1);

      // Back-pressure during a row.
      write_row(0, 0, 24'h0a0b0c);
      step(0, '0, '0, '0, 1);
      step(0, '0, '0, '0, 0);
      step(0, '0, '0, '0, 0);
      step(0, '0, '0, '0, 1);
      idle(6, 1);
      write_row(1, 0, 24'h102030);
      step(0, '0, '0, '0, 0);
      step(0, '0, '0, '0, 1);
      step(0, '0, '0, '0, 0);
      idle(6, 1);

      // Overflow: both banks full, extra row-0 pixel must drop.
      write_row(0, 0, 24'h203040);
      write_row(1, 0, 24'h304050);
      step(1, 4'b0001, 2'b01, 24'hdeadbe, 0);
      idle(12, 1);

      // Bad masks.
      step(1, 4'b0011, 2'b01, 24'h777777, 1);
      step(1, 4'b0001, 2'b00, 24'h888888, 1);
      idle(3, 1);

      // Asynchronous reset mid-row.
      step(1, 4'b0001, 2'b01, 24'haaaaaa, 1);
      step(1, 4'b0010, 2'b01, 24'hbbbbbb, 1);
      #1 Reset = 1'b0;
      #1;
      chk("arst_vld", 32'(OutVld), 32'd0);
      chk("arst_data", 32'(OutPxlData), 32'd0);
      chk("arst_eol", 32'(OutEol), 32'd0);
      chk("arst_eoi", 32'(OutEoi), 32'd0);
      chk("arst_comp", 32'(RszImgComp), 32'd0);
      chk("arst_ovf", 32'(BufOvf), 32'd0);
      chk("arst_err", 32'(MskErr), 32'd0);
      m_reset();
      idle(2, 1);
      Reset = 1'b1;
      step(1, 4'b0100, 2'b01, 24'h121212, 1);
      step(1, 4'b1000, 2'b01, 24'h343434, 1);
      step(1, 4'b0001, 2'b01, 24'h565656, 1);
      idle(3, 1);
      step(1, 4'b0010, 2'b01, 24'h787878, 1);
      idle(6, 1);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         xr = W'(1) << $urandom_range(0, W - 1);
         yr = H'(1) << $urandom_range(0, H - 1);
         if ($urandom_range(0, 19) == 0) xr = W'($urandom_range(0, (1 << W) - 1));
         if ($urandom_range(0, 29) == 0) yr = H'($urandom_range(0, (1 << H) - 1));
         dr = PW'($urandom);
         step($urandom_range(0, 9) < 7, xr, yr, dr, $urandom_range(0, 3) != 0);
      end
      idle(20, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
